sum_avg_acc: RTL and testbench

// - Downstream consumer of the registered 17-bit signed sum produced by the 16x16 two's-complement adder stage.
// - Accumulates 2**LOG2_LEN consecutive valid sums and emits their arithmetic mean (floor, via arithmetic shift).
// - Output uses a valid/ready handshake; the input uses valid/ready so the adder pipeline can be stalled.
// - Sits between the adder output register and the next consumer (e.g. a result FIFO or bus bridge).
//

---
 rtl/sum_avg_acc.sv | 146 ++++++++++++++
 tb/tb_sum_avg_acc.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/sum_avg_acc.sv
// Block averager: accumulates 2**LOG2_LEN signed sums and emits their floor mean over valid/ready.
// Optional feature macro SUM_AVG_SAT_EN: clip the mean to 16 bits signed and flag clipping on out_sat.
module sum_avg_acc #(
    parameter int LOG2_LEN = 2,
    parameter int IN_W     = 17
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic signed [IN_W-1:0] in_sum,
    output logic                   in_ready,
    output logic                   out_valid,
`ifdef SUM_AVG_SAT_EN
    output logic signed [15:0]     out_avg,
`else
    output logic signed [IN_W-1:0] out_avg,
`endif
    input  logic                   out_ready,
    output logic                   out_sat
);

    localparam int ACC_W = IN_W + LOG2_LEN;
    localparam logic [LOG2_LEN-1:0] CNT_LAST = '1;
    localparam logic [LOG2_LEN-1:0] CNT_ONE  = LOG2_LEN'(1);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic signed [ACC_W-1:0] acc_p0;
    logic        [LOG2_LEN-1:0] cnt_p0;
    logic signed [ACC_W-1:0] sum_p0;
    logic signed [IN_W-1:0]  mean_p0;
    logic                    accept;
    logic                    last;

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [IN_W-1:0] v);
        return {{LOG2_LEN{v[IN_W-1]}}, v};
    endfunction

    // Arithmetic shift gives floor (toward -inf) for negative sums.
    function automatic logic signed [IN_W-1:0] mean_floor(input logic signed [ACC_W-1:0] s);
        return IN_W'(s >>> LOG2_LEN);
    endfunction

`ifdef SUM_AVG_SAT_EN
    localparam logic signed [IN_W-1:0] MAX16 = IN_W'(32767);
    localparam logic signed [IN_W-1:0] MIN16 = IN_W'(-32768);

    // Returns {clipped, value16}.
    function automatic logic [16:0] sat16(input logic signed [IN_W-1:0] v);
        if (v > MAX16)
            return {1'b1, 16'h7FFF};
        else if (v < MIN16)
            return {1'b1, 16'h8000};
        else
            return {1'b0, v[15:0]};
    endfunction

    logic        [16:0] sat_res_p0;
    logic signed [15:0] avg_p1;
    logic               sat_p1;
`else
    logic signed [IN_W-1:0] avg_p1;
`endif

    // Control: state register
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_ACC;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACC:  if (accept && last) state_d = ST_HOLD;
            ST_HOLD: if (out_ready)      state_d = ST_ACC;
            default: state_d = ST_ACC;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_ACC) && !rst;
        out_valid = (state_q == ST_HOLD);
    end

    // Stage p0: accumulate
    always_comb begin
        accept  = in_valid && in_ready;
        last    = (cnt_p0 == CNT_LAST);
        sum_p0  = acc_p0 + sext(in_sum);
        mean_p0 = mean_floor(sum_p0);
    end

`ifdef SUM_AVG_SAT_EN
    always_comb begin
        sat_res_p0 = sat16(mean_p0);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_p0 <= '0;
            cnt_p0 <= '0;
        end else if (accept) begin
            if (last) begin
                acc_p0 <= '0;
                cnt_p0 <= '0;
            end else begin
                acc_p0 <= sum_p0;
                cnt_p0 <= cnt_p0 + CNT_ONE;
            end
        end
    end

    // Stage p1: result register, only loaded on the block-closing accept
    always_ff @(posedge clk) begin
        if (rst) begin
            avg_p1 <= '0;
`ifdef SUM_AVG_SAT_EN
            sat_p1 <= 1'b0;
`endif
        end else if (accept && last) begin
`ifdef SUM_AVG_SAT_EN
            avg_p1 <= sat_res_p0[15:0];
            sat_p1 <= sat_res_p0[16];
`else
            avg_p1 <= mean_p0;
`endif
        end
    end

    assign out_avg = avg_p1;
`ifdef SUM_AVG_SAT_EN
    assign out_sat = sat_p1;
`else
    assign out_sat = 1'b0;
`endif

endmodule

// File: tb/tb_sum_avg_acc.sv
// Directed bench for sum_avg_acc (LOG2_LEN=2); expectations follow SUM_AVG_SAT_EN when defined.
module tb_sum_avg_acc;

`ifdef SUM_AVG_SAT_EN
    localparam int OUT_W = 16;
    localparam bit SAT   = 1'b1;
`else
    localparam int OUT_W = 17;
    localparam bit SAT   = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [16:0]      in_sum;
    logic             in_ready;
    logic             out_valid;
    logic [OUT_W-1:0] out_avg;
    logic             out_ready;
    logic             out_sat;

    int errors = 0;
    int checks = 0;

    sum_avg_acc #(.LOG2_LEN(2), .IN_W(17)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sum    (in_sum),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_avg   (out_avg),
        .out_ready (out_ready),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int v);
        in_valid = 1'b1;
        in_sum   = 17'(v);
        step();
    endtask

    task automatic run_block(input string tag, input int a, input int b, input int c, input int d,
                             input int exp_avg, input logic exp_sat);
        logic [OUT_W-1:0] e;
        e = OUT_W'(exp_avg);
        out_ready = 1'b1;
        push(a);
        push(b);
        push(c);
        chk({tag, "_vld_early"}, 32'(out_valid), 32'd0);
        push(d);
        in_valid = 1'b0;
        chk({tag, "_vld"},     32'(out_valid), 32'd1);
        chk({tag, "_avg"},     32'(out_avg),   32'(e));
        chk({tag, "_sat"},     32'(out_sat),   32'(exp_sat));
        chk({tag, "_rdy_hold"},32'(in_ready),  32'd0);
        step();
        chk({tag, "_vld_drop"},32'(out_valid), 32'd0);
        chk({tag, "_rdy_back"},32'(in_ready),  32'd1);
    endtask

    initial begin
        bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sum    = '0;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_vld", 32'(out_valid), 32'd0);
        chk("rst_rdy", 32'(in_ready),  32'd0);
        chk("rst_avg", 32'(out_avg),   32'd0);
        chk("rst_sat", 32'(out_sat),   32'd0);
        rst = 1'b0;
        step();
        chk("post_rst_rdy", 32'(in_ready), 32'd1);

        run_block("basic",  10, 20, 30, 40, 25, 1'b0);
        run_block("floor5", -1, -1, -1, -2, -2, 1'b0);
        run_block("neg4",   -4, -4, -4, -4, -4, 1'b0);
        run_block("satpos", 65534, 65534, 65534, 65534, SAT ? 32767 : 65534, SAT);
        run_block("satneg", -65536, -65536, -65536, -65536, SAT ? -32768 : -65536, SAT);

        // Backpressure: the 99s offered while holding must not be absorbed.
        out_ready = 1'b0;
        push(5); push(5); push(5); push(5);
        in_valid = 1'b1;
        in_sum   = 17'd99;
        for (int i = 0; i < 5; i++) begin
            chk("bp_vld", 32'(out_valid), 32'd1);
            chk("bp_avg", 32'(out_avg),   32'd5);
            chk("bp_rdy", 32'(in_ready),  32'd0);
            step();
        end
        chk("bp_vld_end", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        step();
        chk("bp_release", 32'(out_valid), 32'd0);
        run_block("bp_next", 1, 2, 3, 6, 3, 1'b0);

        // Gaps: junk on in_sum while in_valid is low.
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = pat[i];
            in_sum   = pat[i] ? 17'd8 : 17'd1000;
            step();
            if (i < 6) chk("gap_vld_early", 32'(out_valid), 32'd0);
        end
        in_valid = 1'b0;
        chk("gap_vld", 32'(out_valid), 32'd1);
        chk("gap_avg", 32'(out_avg),   32'd8);
        step();
        chk("gap_drop", 32'(out_valid), 32'd0);

        // Reset with a partial block.
        push(100);
        push(100);
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        chk("midrst_rdy", 32'(in_ready),  32'd0);
        rst = 1'b0;
        chk("midrst_vld", 32'(out_valid), 32'd0);
        run_block("after_rst", 1, 1, 1, 1, 1, 1'b0);

        // Reset with a pending output discards it.
        out_ready = 1'b0;
        push(7); push(7); push(7); push(7);
        in_valid = 1'b0;
        chk("pend_vld", 32'(out_valid), 32'd1);
        chk("pend_avg", 32'(out_avg),   32'd7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("pend_rst_vld", 32'(out_valid), 32'd0);
        chk("pend_rst_avg", 32'(out_avg),   32'd0);
        step();
        chk("pend_rst_rdy", 32'(in_ready),  32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
